pc_branch_seq: RTL

- Registered program-counter sequencer with relative branch, absolute jump and call/return through a small return-address stack (RAS).
- Successor to the combinational branch adder: PC and offset widths are parametrised, and the block holds PC state itself.
- Sits between instruction decode (branch/jump/call/ret strobes) and instruction memory address.

---
 rtl/pc_branch_seq_pkg.sv | 31 +++
 rtl/pc_branch_seq_if.sv | 48 ++++
 rtl/pc_branch_seq_ras_stack.sv | 58 +++++
 rtl/pc_branch_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pc_branch_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared types and helpers for the pc_branch_seq sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_RET  = 3'd1,
        ACT_CALL = 3'd2,
        ACT_JUMP = 3'd3,
        ACT_BR   = 3'd4,
        ACT_INC  = 3'd5
    } seq_act_t;

    // Sign-extends the low off_w bits of off to 32 bits.
    function automatic logic [31:0] sext_offset(input logic [31:0] off, input int off_w);
        logic signed [31:0] t;
        t = $signed(off << (32 - off_w));
        return t >>> (32 - off_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_branch_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_seq_if
//  Description : Decode-side control strobes and sequencer status bundle.
//                Br_Wrap exists only when BRANCH_WRAP_DET_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_branch_seq_if #(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 5,
    parameter int RAS_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(RAS_DEPTH) + 1;

    logic               Run;
    logic               Stall;
    logic               Branch;
    logic [OFF_W-1:0]   Offset;
    logic               Jump;
    logic               Call;
    logic               Ret;
    logic [PC_W-1:0]    Target;
    logic [PC_W-1:0]    PC;
    logic               Ras_Ovf;
    logic               Ras_Unf;
    logic [c_CNT_W-1:0] Ras_Count;
`ifdef BRANCH_WRAP_DET_EN
    logic               Br_Wrap;
`endif

    modport master (
        output Run, Stall, Branch, Offset, Jump, Call, Ret, Target,
`ifdef BRANCH_WRAP_DET_EN
        input  Br_Wrap,
`endif
        input  PC, Ras_Ovf, Ras_Unf, Ras_Count
    );

    modport slave (
        input  Run, Stall, Branch, Offset, Jump, Call, Ret, Target,
`ifdef BRANCH_WRAP_DET_EN
        output Br_Wrap,
`endif
        output PC, Ras_Ovf, Ras_Unf, Ras_Count
    );

endinterface
`default_nettype wire

// File: rtl/pc_branch_seq_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address LIFO; a push when full overwrites
//                the oldest entry.
//  Revision    : 1.0  initial release
// ============================================================================
module ras_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [DATA_W-1:0]          i_push_data,
    output logic      [DATA_W-1:0]          o_pop_data,
    output logic      [$clog2(DEPTH):0]     o_count,
    output logic                            o_full,
    output logic                            o_empty
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_sp;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_top;

    assign w_top      = r_sp - c_PTR_W'(1);
    assign o_pop_data = r_mem[w_top];
    assign o_count    = r_count;
    assign o_full     = (r_count == c_CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);

    // With a power-of-two depth the write pointer naturally lands on the
    // oldest entry once the stack is full.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_sp] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_sp    <= r_sp + c_PTR_W'(1);
            r_count <= o_full ? r_count : r_count + c_CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            r_sp    <= w_top;
            r_count <= r_count - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_branch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_seq
//  Description : Registered PC sequencer with branch, jump and call/return.
//                Define BRANCH_WRAP_DET_EN to add the Br_Wrap output.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_branch_seq
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              OFF_W     = 5,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  wire logic       CLK,
    input  wire logic       Reset,
    pc_branch_seq_if.slave  bus
);
    localparam int c_CNT_W = $clog2(RAS_DEPTH) + 1;

    seq_state_t         r_state, w_state_nxt;
    seq_act_t           w_act;
    logic [PC_W-1:0]    r_pc, w_pc_nxt, w_pc_inc, w_pc_br, w_pop_data;
    logic               r_ovf, r_unf;
    logic               w_full, w_empty, w_push, w_pop;
    logic [c_CNT_W-1:0] w_count;

    assign w_pc_inc = r_pc + PC_W'(1);

`ifdef BRANCH_WRAP_DET_EN
    // Two guard bits: bit PC_W flags overflow, bit PC_W+1 a negative result.
    logic [PC_W+1:0] w_off_ext, w_sum_ext;
    logic            w_br_wrap, r_br_wrap;
    assign w_off_ext = (PC_W+2)'(sext_offset(32'(bus.Offset), OFF_W));
    assign w_sum_ext = {2'b00, r_pc} + w_off_ext;
    assign w_pc_br   = w_sum_ext[PC_W-1:0];
    assign w_br_wrap = |w_sum_ext[PC_W+1:PC_W];
    assign bus.Br_Wrap = r_br_wrap;
`else
    assign w_pc_br = r_pc + PC_W'(sext_offset(32'(bus.Offset), OFF_W));
`endif

    // The edge that enters RUN only changes state; PC starts moving next edge.
    always_comb begin
        w_state_nxt = r_state;
        w_act       = ACT_HOLD;
        case (r_state)
            IDLE: begin
                if (bus.Run) w_state_nxt = RUN;
            end
            RUN: begin
                if (!bus.Run)       w_state_nxt = IDLE;
                else if (bus.Stall)  w_act = ACT_HOLD;
                else if (bus.Ret)    w_act = ACT_RET;
                else if (bus.Call)   w_act = ACT_CALL;
                else if (bus.Jump)   w_act = ACT_JUMP;
                else if (bus.Branch) w_act = ACT_BR;
                else                 w_act = ACT_INC;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        case (w_act)
            ACT_RET:  w_pc_nxt = w_empty ? w_pc_inc : w_pop_data;
            ACT_CALL: w_pc_nxt = bus.Target;
            ACT_JUMP: w_pc_nxt = bus.Target;
            ACT_BR:   w_pc_nxt = w_pc_br;
            ACT_INC:  w_pc_nxt = w_pc_inc;
            default:  w_pc_nxt = r_pc;
        endcase
    end

    assign w_push = (w_act == ACT_CALL);
    assign w_pop  = (w_act == ACT_RET) && !w_empty;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_push && w_full)                r_ovf <= 1'b1;
            if ((w_act == ACT_RET) && w_empty)   r_unf <= 1'b1;
        end
    end

`ifdef BRANCH_WRAP_DET_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_br_wrap <= 1'b0;
        else       r_br_wrap <= (w_act == ACT_BR) && w_br_wrap;
    end
`endif

    ras_stack #(
        .DATA_W (PC_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (CLK),
        .rst         (Reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_pop_data  (w_pop_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.PC        = r_pc;
    assign bus.Ras_Ovf   = r_ovf;
    assign bus.Ras_Unf   = r_unf;
    assign bus.Ras_Count = w_count;

endmodule
`default_nettype wire
